counter_interval_ctrl: RTL and testbench

Interval-timer controller that sequences an external n-bit synchronous counter. That counter loads its init value when its SR is high and increments by 1 when its CE is high, with one-cycle latency and modulo-2^SIZE wrap. Software/upstream logic issues a START with a start value, terminal value and mode. The controller then loads the counter, enables counting until the terminal value is reached, and emits a one-cycle DONE pulse, once (one-shot) or repeatedly (periodic). It is the sequencing layer between control logic and the counter datapath.

---
 rtl/counter_interval_ctrl.sv | 95 +++++++++
 tb/tb_counter_interval_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_interval_ctrl.sv
// Interval-timer sequencer for an external load/enable counter (LOAD -> RUN -> DONE).
// Define CTRL_PRESCALE_EN to divide the count rate by PRESCALE.
module counter_interval_ctrl #(
  parameter int SIZE     = 8,
  parameter int PRESCALE = 4
) (
  input  logic            CLK,
  input  logic            SR,
  input  logic            START,
  input  logic            STOP,
  input  logic            MODE,
  input  logic [SIZE-1:0] INIT,
  input  logic [SIZE-1:0] TERM,
  output logic            BUSY,
  output logic            DONE,
  output logic            CNT_CE,
  output logic            CNT_SR,
  output logic [SIZE-1:0] CNT_SRINIT,
  input  logic [SIZE-1:0] CNT_DOUT,
  output logic [1:0]      DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [SIZE-1:0] init_q;
  logic [SIZE-1:0] term_q;
  logic            mode_q;
  logic            tick;
  logic            at_term;

  assign at_term = (CNT_DOUT == term_q);

`ifdef CTRL_PRESCALE_EN
  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  always_ff @(posedge CLK) begin
    if (SR) begin
      pre_q <= '0;
    end else if (state == S_LOAD) begin
      pre_q <= '0;
    end else if (state == S_RUN) begin
      pre_q <= (pre_q == P_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  assign tick = (pre_q == P_LAST);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (SR) begin
      state  <= S_IDLE;
      init_q <= '0;
      term_q <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START && !STOP) begin
            init_q <= INIT;
            term_q <= TERM;
            mode_q <= MODE;
            state  <= S_LOAD;
          end
        end
        S_LOAD: state <= STOP ? S_IDLE : S_RUN;
        S_RUN: begin
          if (STOP)         state <= S_IDLE;
          else if (at_term) state <= S_DONE;
        end
        S_DONE: state <= (STOP || !mode_q) ? S_IDLE : S_LOAD;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY       = (state != S_IDLE);
  assign DONE       = (state == S_DONE);
  assign CNT_SR     = SR || (state == S_LOAD);
  assign CNT_SRINIT = SR ? '0 : init_q;
  // Enable is gated by STOP/SR in the same cycle so an abort freezes the count immediately.
  assign CNT_CE     = (state == S_RUN) && !STOP && !SR && !at_term && tick;
  assign DBG_STATE  = state;

endmodule

// File: tb/tb_counter_interval_ctrl.sv
// Directed bench for counter_interval_ctrl with a behavioural counter and a DONE-cycle scoreboard.
module tb_counter_interval_ctrl;

  logic       CLK = 1'b0;
  logic       SR = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       MODE = 1'b0;
  logic [7:0] INIT = '0;
  logic [7:0] TERM = '0;
  logic       BUSY, DONE, CNT_CE, CNT_SR;
  logic [7:0] CNT_SRINIT;
  logic [7:0] CNT_DOUT;
  logic [1:0] DBG_STATE;

  int cyc = 0;
  int t0 = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  counter_interval_ctrl #(.SIZE(8), .PRESCALE(3)) dut (
    .CLK(CLK), .SR(SR), .START(START), .STOP(STOP), .MODE(MODE),
    .INIT(INIT), .TERM(TERM), .BUSY(BUSY), .DONE(DONE), .CNT_CE(CNT_CE),
    .CNT_SR(CNT_SR), .CNT_SRINIT(CNT_SRINIT), .CNT_DOUT(CNT_DOUT),
    .DBG_STATE(DBG_STATE)
  );

  // clock / cycle counter / external counter model
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] cnt;
  always @(posedge CLK) begin
    if (CNT_SR)      cnt <= CNT_SRINIT;
    else if (CNT_CE) cnt <= cnt + 8'd1;
  end
  assign CNT_DOUT = cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input int k);
    while (cyc - t0 < k) step();
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic start_run(input logic m, input logic [7:0] i, input logic [7:0] t);
    START = 1'b1;
    MODE  = m;
    INIT  = i;
    TERM  = t;
    t0    = cyc;
    step();
    START = 1'b0;
  endtask

  // scoreboard monitor: every DONE pulse must match the next expected absolute cycle
  always @(negedge CLK) begin
    if (!SR && DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        chk("done_cycle", 32'(cyc), exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) step();
    samp();
    chk("rst_cnt_sr", CNT_SR, 1);
    chk("rst_srinit", CNT_SRINIT, 0);
    step();
    SR = 1'b0;
    samp();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ce", CNT_CE, 0);
    chk("rst_sr_out", CNT_SR, 0);
    chk("rst_state", DBG_STATE, 0);

`ifdef CTRL_PRESCALE_EN
    // P=3, INIT=0/TERM=2: enable pulses at cycles 4 and 7, DONE at 9
    start_run(1'b0, 8'd0, 8'd2);
    exp_q.push_back(32'(t0 + 9));
    for (int k = 2; k <= 8; k++) begin
      go(k);
      samp();
      chk("pre_ce", CNT_CE, (k == 4 || k == 7) ? 1 : 0);
    end
    go(10); samp();
    chk("pre_busy_end", BUSY, 0);
`else
    // one-shot 3 -> 7
    start_run(1'b0, 8'd3, 8'd7);
    exp_q.push_back(32'(t0 + 7));
    samp();
    chk("os_load_sr", CNT_SR, 1);
    chk("os_load_busy", BUSY, 1);
    chk("os_load_init", CNT_SRINIT, 3);
    for (int k = 2; k <= 6; k++) begin
      go(k);
      samp();
      chk("os_dout", CNT_DOUT, 32'(k + 1));
    end
    go(7); samp();
    chk("os_done", DONE, 1);
    go(8); samp();
    chk("os_busy_end", BUSY, 0);
    chk("os_state_end", DBG_STATE, 0);

    // periodic 0 -> 2, started in the cycle BUSY fell
    start_run(1'b1, 8'd0, 8'd2);
    exp_q.push_back(32'(t0 + 5));
    exp_q.push_back(32'(t0 + 10));
    exp_q.push_back(32'(t0 + 15));
    go(6);  samp(); chk("per_reload1", CNT_SR, 1);
    go(11); samp(); chk("per_reload2", CNT_SR, 1);
    go(12); samp(); chk("per_busy", BUSY, 1);
    go(16);
    STOP = 1'b1;
    samp();
    chk("per_stop_load", DBG_STATE, 1);
    go(17);
    STOP = 1'b0;
    samp();
    chk("per_stop_busy", BUSY, 0);
    go(22);

    // wrap 250 -> 4 (N=10)
    start_run(1'b0, 8'd250, 8'd4);
    exp_q.push_back(32'(t0 + 13));
    go(7);  samp(); chk("wrap_dout255", CNT_DOUT, 255);
    go(8);  samp(); chk("wrap_dout0", CNT_DOUT, 0);
    go(14); samp(); chk("wrap_busy_end", BUSY, 0);

    // INIT == TERM gives N=0
    start_run(1'b0, 8'd9, 8'd9);
    exp_q.push_back(32'(t0 + 3));
    go(2); samp();
    chk("zero_dout", CNT_DOUT, 9);
    chk("zero_ce", CNT_CE, 0);
    go(4); samp();
    chk("zero_busy_end", BUSY, 0);

    // STOP mid-run: no DONE, counter frozen
    start_run(1'b0, 8'd0, 8'd10);
    go(4);
    STOP = 1'b1;
    samp();
    chk("stop_ce", CNT_CE, 0);
    chk("stop_busy", BUSY, 1);
    go(5);
    STOP = 1'b0;
    samp();
    chk("stop_idle_busy", BUSY, 0);
    chk("stop_idle_state", DBG_STATE, 0);
    chk("stop_dout", CNT_DOUT, 2);
    go(14); samp();
    chk("stop_dout_late", CNT_DOUT, 2);
    go(15);
    START = 1'b1;
    STOP  = 1'b1;
    step();
    START = 1'b0;
    STOP  = 1'b0;
    samp();
    chk("startstop_busy", BUSY, 0);
    chk("startstop_sr", CNT_SR, 0);

    // SR mid-run aborts, then a fresh START is accepted
    start_run(1'b0, 8'd5, 8'd20);
    go(4);
    SR = 1'b1;
    samp();
    chk("sr_cnt_sr", CNT_SR, 1);
    chk("sr_srinit", CNT_SRINIT, 0);
    go(5);
    SR = 1'b0;
    samp();
    chk("sr_busy", BUSY, 0);
    chk("sr_done", DONE, 0);
    chk("sr_ce", CNT_CE, 0);
    chk("sr_sr_out", CNT_SR, 0);
    chk("sr_srinit_q", CNT_SRINIT, 0);
    chk("sr_state", DBG_STATE, 0);
    start_run(1'b0, 8'd1, 8'd3);
    exp_q.push_back(32'(t0 + 5));
    samp();
    chk("sr_restart_sr", CNT_SR, 1);
    chk("sr_restart_init", CNT_SRINIT, 1);
    go(6); samp();
    chk("sr_restart_end", BUSY, 0);
`endif

    repeat (10) step();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
